// File: rtl/fp_rnd_pipe_pkg.sv
// fp_wire: shared types and constants for the fp_rnd_pipe rounding slice.
// Input bundle, rounding modes, canonical NaNs and stage registers.
package fp_wire;

  typedef struct packed {
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic [1:0]  rema;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [2:0]  grs;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
    logic        diff;
  } fp_rnd_in_type;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam logic [31:0] NAN_S = 32'h7FC00000;
  localparam logic [63:0] NAN_D = 64'h7FF8000000000000;

  typedef struct packed {
    logic        valid;
    logic        sig;
    logic [13:0] expo;
    logic [53:0] mant;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic        nx;
    logic        uf;
    logic        ofe;
    logic        snan;
    logic        qnan;
    logic        dbz;
    logic        inf;
    logic        zero;
    logic        diff;
  } fp_rnd_s1_t;

  localparam fp_rnd_s1_t S1_INIT = '0;

  typedef struct packed {
    logic        valid;
    logic [63:0] result;
    logic [4:0]  flags;
  } fp_rnd_s2_t;

  localparam fp_rnd_s2_t S2_INIT = '0;

  function automatic logic [13:0] fp_emax(
    input logic [1:0] fmt
  );
    return (fmt == 2'd0) ? 14'd255 : 14'd2047;
  endfunction

  function automatic logic [63:0] fp_pack(
    input logic        dbl,
    input logic        s,
    input logic [13:0] e,
    input logic [53:0] m,
    input logic [31:0] up
  );
    if (dbl)
      return {s, e[10:0], m[51:0]};
    return {up, s, e[7:0], m[22:0]};
  endfunction

endpackage

// File: rtl/fp_rnd_pipe_inc.sv
// fp_rnd_inc: rounding increment decision from mode, sign, lsb and g/r/s.
// Purely combinational; feeds the stage-1 adder.
module fp_rnd_inc
  import fp_wire::*;
(
  input  logic [2:0] rm,
  input  logic       sig,
  input  logic       lsb,
  input  logic [2:0] grs,
  output logic       inc
);

  // select the increment rule for the active rounding mode
  always_comb begin
    inc = 1'b0;
    unique case (rm)
      RM_RNE:  inc = grs[2] & (grs[1] | grs[0] | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sig & (|grs);
      RM_RUP:  inc = ~sig & (|grs);
      RM_RMM:  inc = grs[2];
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage IEEE-754 round-and-pack with valid/ready flow.
// FP_RND_NANBOX_EN: single results carry an all-ones upper word.
module fp_rnd_pipe
  import fp_wire::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  fp_rnd_in_type fp_rnd_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [63:0]   result,
  output logic [4:0]    flags
);

`ifdef FP_RND_NANBOX_EN
  localparam logic [31:0] UPPER = 32'hFFFFFFFF;
`else
  localparam logic [31:0] UPPER = 32'h0;
`endif

  fp_rnd_s1_t s1_d, s1_q;
  fp_rnd_s2_t s2_d, s2_q;

  logic        dbl1;
  logic [13:0] emx1;
  logic [53:0] mask;
  logic [53:0] mant_m;
  logic        inc;
  logic [54:0] sum;
  logic        carry;
  logic        hid;

  assign dbl1   = fp_rnd_i.fmt != 2'd0;
  assign emx1   = fp_emax(fp_rnd_i.fmt);
  assign mask   = dbl1 ? 54'h1FFFFFFFFFFFFF
                       : 54'hFFFFFF;
  assign mant_m = fp_rnd_i.mant & mask;
  assign sum    = {1'b0, mant_m} + 55'(inc);
  assign carry  = dbl1 ? sum[53] : sum[24];
  assign hid    = dbl1 ? sum[52] : sum[23];

  fp_rnd_inc u_inc (
    .rm  (fp_rnd_i.rm),
    .sig (fp_rnd_i.sig),
    .lsb (mant_m[0]),
    .grs (fp_rnd_i.grs),
    .inc (inc)
  );

  logic unused;
  assign unused = ^{fp_rnd_i.rema, sum[54]};

  // stage 1: apply the increment and renormalise on carry
  always_comb begin
    s1_d       = S1_INIT;
    s1_d.valid = in_valid;
    s1_d.sig   = fp_rnd_i.sig;
    s1_d.fmt   = fp_rnd_i.fmt;
    s1_d.rm    = fp_rnd_i.rm;
    s1_d.snan  = fp_rnd_i.snan;
    s1_d.qnan  = fp_rnd_i.qnan;
    s1_d.dbz   = fp_rnd_i.dbz;
    s1_d.inf   = fp_rnd_i.inf;
    s1_d.zero  = fp_rnd_i.zero;
    s1_d.diff  = fp_rnd_i.diff;
    s1_d.nx    = |fp_rnd_i.grs;
    s1_d.uf    = (fp_rnd_i.expo == 14'd0)
               & (|fp_rnd_i.grs);
    s1_d.ofe   = (fp_rnd_i.expo == emx1 - 14'd1)
               & (mant_m == mask)
               & (|fp_rnd_i.grs);
    if (carry) begin
      s1_d.mant = dbl1 ? 54'h10000000000000
                       : 54'h800000;
      s1_d.expo = fp_rnd_i.expo + 14'd1;
    end else begin
      s1_d.mant = sum[53:0];
      s1_d.expo = fp_rnd_i.expo;
      if (fp_rnd_i.expo == 14'd0 && hid)
        s1_d.expo = 14'd1;
    end
  end

  logic        dbl2;
  logic [13:0] emx2;
  logic        ovf;
  logic        to_inf;
  logic        zsg;

  assign dbl2   = s1_q.fmt != 2'd0;
  assign emx2   = fp_emax(s1_q.fmt);
  assign ovf    = s1_q.expo >= emx2;
  assign to_inf = (s1_q.rm == RM_RNE)
                | (s1_q.rm == RM_RMM)
                | (s1_q.rm == RM_RUP & ~s1_q.sig)
                | (s1_q.rm == RM_RDN & s1_q.sig);
  assign zsg    = s1_q.diff ? (s1_q.rm == RM_RDN)
                            : s1_q.sig;

  // stage 2: specials by precedence, overflow, else pack
  always_comb begin
    s2_d       = S2_INIT;
    s2_d.valid = s1_q.valid;
    if (s1_q.snan) begin
      s2_d.result = dbl2 ? NAN_D : {UPPER, NAN_S};
      s2_d.flags  = 5'b10000;
    end else if (s1_q.qnan) begin
      s2_d.result = dbl2 ? NAN_D : {UPPER, NAN_S};
    end else if (s1_q.inf) begin
      s2_d.result = fp_pack(dbl2, s1_q.sig, emx2,
                            54'h0, UPPER);
      s2_d.flags  = {1'b0, s1_q.dbz, 3'b000};
    end else if (s1_q.zero) begin
      s2_d.result = fp_pack(dbl2, zsg, 14'd0,
                            54'h0, UPPER);
    end else if (ovf) begin
      s2_d.result = to_inf
        ? fp_pack(dbl2, s1_q.sig, emx2,
                  54'h0, UPPER)
        : fp_pack(dbl2, s1_q.sig, emx2 - 14'd1,
                  '1, UPPER);
      s2_d.flags  = 5'b00101;
    end else begin
      s2_d.result = fp_pack(dbl2, s1_q.sig, s1_q.expo,
                            s1_q.mant, UPPER);
      s2_d.flags  = {2'b00, s1_q.ofe,
                     s1_q.uf, s1_q.nx};
    end
  end

  assign in_ready = ~s2_q.valid | out_ready;

  // both stages advance together on the global enable
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= S1_INIT;
      s2_q <= S2_INIT;
    end else if (in_ready) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign out_valid = s2_q.valid;
  assign result    = s2_q.result;
  assign flags     = s2_q.flags;

endmodule

// File: tb/tb_fp_rnd_pipe.sv
// tb_fp_rnd_pipe: directed vectors with a queue-based scoreboard.
// Driver pushes expectations on accept; monitor pops on each transfer.
module tb_fp_rnd_pipe;
  import fp_wire::*;

`ifdef FP_RND_NANBOX_EN
  localparam logic [31:0] UP = 32'hFFFFFFFF;
`else
  localparam logic [31:0] UP = 32'h0;
`endif

  logic          clock;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  fp_rnd_in_type fp_rnd_i;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   result;
  logic [4:0]    flags;

  fp_rnd_pipe dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_rnd_i  (fp_rnd_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  typedef struct {
    string       name;
    logic [63:0] res;
    logic [4:0]  flg;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    #1;
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_output: result=%h flags=%b",
                 result, flags);
      end else begin
        me = q.pop_front();
        if (result !== me.res || flags !== me.flg) begin
          n_bad++;
          $display("FAIL %s: got %h/%b want %h/%b",
                   me.name, result, flags, me.res, me.flg);
        end
        if (me.lat) begin
          n_cmp++;
          if (cyc - me.cyc != 2) begin
            n_bad++;
            $display("FAIL %s_latency: got %0d want 2",
                     me.name, cyc - me.cyc);
          end
        end
      end
    end
  end

  function automatic fp_rnd_in_type mk(
    input logic        s,
    input logic [13:0] e,
    input logic [53:0] m,
    input logic [1:0]  f,
    input logic [2:0]  rm,
    input logic [2:0]  g
  );
    fp_rnd_in_type o;
    o      = '0;
    o.sig  = s;
    o.expo = e;
    o.mant = m;
    o.fmt  = f;
    o.rm   = rm;
    o.grs  = g;
    o.rema = 2'b11;
    return o;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // called at a falling edge; returns at a falling edge
  task automatic send(input string nm,
                      input fp_rnd_in_type op,
                      input logic [63:0] r,
                      input logic [4:0] f,
                      input bit lat,
                      input bit push);
    int   k;
    exp_t e;
    in_valid = 1'b1;
    fp_rnd_i = op;
    #1;
    k = 0;
    while (!in_ready && k < 50) begin
      @(negedge clock);
      #1;
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept_timeout: in_ready=%b want 1",
               nm, in_ready);
    end else if (push) begin
      e.name = nm;
      e.res  = r;
      e.flg  = f;
      e.cyc  = cyc;
      e.lat  = lat;
      q.push_back(e);
    end
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(negedge clock);
      k++;
    end
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: pending=%0d want 0", q.size());
    end
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: timeout want finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  fp_rnd_in_type t;
  logic [63:0]   r0;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    fp_rnd_i  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", 64'(flags), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clock);

    send("d_one", mk(0, 1023, 54'h10000000000000, 1, RM_RNE, 0),
         64'h3FF0000000000000, 5'b00000, 1, 1);
    drain();
    send("tie_odd", mk(0, 1023, 54'h10000000000001, 1, RM_RNE, 3'b100),
         64'h3FF0000000000002, 5'b00001, 0, 1);
    send("tie_even", mk(0, 1023, 54'h10000000000000, 1, RM_RNE, 3'b100),
         64'h3FF0000000000000, 5'b00001, 0, 1);
    send("s_ovf_rne", mk(0, 254, 54'hFFFFFF, 0, RM_RNE, 3'b110),
         {UP, 32'h7F800000}, 5'b00101, 0, 1);
    send("s_ovf_rtz", mk(0, 254, 54'hFFFFFF, 0, RM_RTZ, 3'b110),
         {UP, 32'h7F7FFFFF}, 5'b00101, 0, 1);
    t = mk(0, 1023, 54'h10000000000000, 1, RM_RNE, 0);
    t.snan = 1'b1;
    t.inf  = 1'b1;
    send("snan", t, 64'h7FF8000000000000, 5'b10000, 0, 1);
    t = mk(0, 0, 0, 1, RM_RDN, 0);
    t.zero = 1'b1;
    t.diff = 1'b1;
    send("zero_diff_rdn", t, 64'h8000000000000000, 5'b00000, 0, 1);
    t = mk(1, 0, 0, 1, RM_RNE, 0);
    t.zero = 1'b1;
    send("zero_neg", t, 64'h8000000000000000, 5'b00000, 0, 1);
    t = mk(0, 0, 0, 0, RM_RNE, 0);
    t.qnan = 1'b1;
    send("s_qnan", t, {UP, 32'h7FC00000}, 5'b00000, 0, 1);
    t = mk(1, 0, 0, 1, RM_RNE, 0);
    t.inf = 1'b1;
    t.dbz = 1'b1;
    send("inf_dbz", t, 64'hFFF0000000000000, 5'b01000, 0, 1);
    send("rup_pos", mk(0, 1023, 54'h10000000000000, 1, RM_RUP, 3'b001),
         64'h3FF0000000000001, 5'b00001, 0, 1);
    send("rdn_neg", mk(1, 1023, 54'h10000000000000, 1, RM_RDN, 3'b001),
         64'hBFF0000000000001, 5'b00001, 0, 1);
    send("rdn_pos", mk(0, 1023, 54'h10000000000000, 1, RM_RDN, 3'b011),
         64'h3FF0000000000000, 5'b00001, 0, 1);
    send("s_rmm", mk(0, 127, 54'h800000, 0, RM_RMM, 3'b100),
         {UP, 32'h3F800001}, 5'b00001, 0, 1);
    send("s_sub2norm", mk(0, 0, 54'h7FFFFF, 0, RM_RNE, 3'b100),
         {UP, 32'h00800000}, 5'b00011, 0, 1);
    send("d_carry", mk(0, 1023, 54'h1FFFFFFFFFFFFF, 1, RM_RNE, 3'b111),
         64'h4000000000000000, 5'b00001, 0, 1);
    send("d_ovf_rdn", mk(1, 2046, 54'h1FFFFFFFFFFFFF, 1, RM_RDN, 3'b100),
         64'hFFF0000000000000, 5'b00101, 0, 1);
    send("d_ovf_rup", mk(1, 2046, 54'h1FFFFFFFFFFFFF, 1, RM_RUP, 3'b100),
         64'hFFEFFFFFFFFFFFFF, 5'b00101, 0, 1);
    drain();

    out_ready = 1'b0;
    fork
      begin
        send("bp0", mk(0, 1023, 54'h10000000000001, 1, RM_RNE, 0),
             64'h3FF0000000000001, 5'b00000, 0, 1);
        send("bp1", mk(0, 1023, 54'h10000000000002, 1, RM_RNE, 0),
             64'h3FF0000000000002, 5'b00000, 0, 1);
        send("bp2", mk(0, 1023, 54'h10000000000003, 1, RM_RNE, 0),
             64'h3FF0000000000003, 5'b00000, 0, 1);
      end
      begin
        int k;
        k = 0;
        @(negedge clock);
        #1;
        while (!out_valid && k < 50) begin
          @(negedge clock);
          #1;
          k++;
        end
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        r0 = result;
        repeat (4) begin
          @(negedge clock);
          #1;
          chk("bp_in_ready", 64'(in_ready), 64'd0);
          chk("bp_hold", result, r0);
        end
        @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    send("rs_a", mk(0, 1023, 54'h10000000000005, 1, RM_RNE, 0),
         64'h0, 5'b0, 0, 0);
    send("rs_b", mk(0, 1023, 54'h10000000000006, 1, RM_RNE, 0),
         64'h0, 5'b0, 0, 0);
    reset = 1'b1;
    @(negedge clock);
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_result", result, 64'd0);
    repeat (4) begin
      @(negedge clock);
      #1;
      chk("mid_rst_quiet", 64'(out_valid), 64'd0);
    end
    @(negedge clock);
    send("post_rst", mk(0, 1023, 54'h10000000000007, 1, RM_RNE, 0),
         64'h3FF0000000000007, 5'b00000, 1, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_rnd_pipe.md
FP_RND_PIPE -- requirements
Module: fp_rnd_pipe

Interface
REQ-001 SHALL have port clock, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port in_valid, input, 1, an operand is present on the fp_rnd inputs.
REQ-004 SHALL have port in_ready, output, 1, the block accepts the operand this cycle.
REQ-005 SHALL have port fp_rnd_i, input, struct, fields: sig 1, expo 14, mant 54, rema 2, fmt 2, rm 3, grs 3, snan, qnan, dbz, inf, zero, diff (1 each).
REQ-006 SHALL have port out_valid, output, 1, result and flags are valid.
REQ-007 SHALL have port out_ready, input, 1, the consumer takes the result this cycle.
REQ-008 SHALL have port result, output, 64, packed IEEE-754 result.
REQ-009 SHALL have port flags, output, 5, {NV,DZ,OF,UF,NX}.

Function
REQ-010 SHALL accept an operand on in_valid&in_ready and present it on out_valid exactly 2 cycles later when no stall occurs.
REQ-011 SHALL use a global advance enable: in_ready = ~out_valid | out_ready.
REQ-012 SHALL freeze both stages and hold result/flags stable while out_valid&~out_ready.
REQ-013 SHALL propagate bubbles: an empty input slot produces out_valid=0 two advances later.
REQ-014 SHALL treat fmt 0 as single (mant[23:0], exponent max 255) and fmt 1 as double (mant[52:0], exponent max 2047).
REQ-015 SHALL implement rounding per rm (grs = guard, round, sticky):
- RNE (0): increment when g&(r|s|lsb).
- RTZ (1): never increment.
- RDN (2): increment when sig&(g|r|s).
- RUP (3): increment when ~sig&(g|r|s).
- RMM (4): increment when g.
REQ-016 SHALL, in stage 1, add the increment; a carry out of the mantissa sets the mantissa to the hidden one and increments expo.
REQ-017 SHALL, in stage 1, make a subnormal (expo 0) whose rounding carries into the hidden bit become expo 1.
REQ-018 SHALL, in stage 2, handle overflow (expo ≥ max): result is ±inf for RNE/RMM, for RUP when positive and for RDN when negative; otherwise ±max-finite; flags set OF|NX.
REQ-019 SHALL set NX when grs≠0 and UF when expo was 0 before rounding and grs≠0.
REQ-020 SHALL give special cases precedence snan > qnan > inf > zero:
- snan: canonical NaN, flags NV.
- qnan: canonical NaN, no flag.
- inf: ±inf with sign sig, DZ when dbz.
- zero with diff: sign = (rm==RDN); zero without diff: sign = sig.
REQ-021 SHALL use canonical NaN 0x7FC00000 (single) and 0x7FF8000000000000 (double).
REQ-022 SHALL ignore rema.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, clear both stage valid bits, result=0 and flags=0; out_valid=0 in the following cycle.
REQ-024 SHALL discard any operand in flight when reset asserts; no partial result appears after reset.
REQ-025 SHALL make in_ready=1 in the first cycle after reset deasserts.

Configuration
REQ-026 SHALL, with FP_RND_NANBOX_EN defined, drive result[63:32] all ones for fmt 0 results; without it, drive result[63:32] zero.

Structure
REQ-027 SHALL place the fp_rnd_in_type struct, rounding-mode constants, canonical NaN constants and the stage register types with init values in package fp_wire.
REQ-028 SHALL instantiate one sub-module, fp_rnd_inc, a combinational increment decision (rm, sig, lsb, grs → inc).

Verification
REQ-029 SHALL cover exact double 1.0: fmt 1, expo 1023, mant 54'h10000000000000, grs 0, RNE → result 0x3FF0000000000000, flags 0, out_valid 2 cycles after accept.
REQ-030 SHALL cover RNE tie-to-even: double, mant lsb 1, grs 100 → mantissa incremented by 1, flags 00001; same with lsb 0 → unchanged, flags 00001.
REQ-031 SHALL cover single overflow: expo 254, mant 24'hFFFFFF, grs 110:
- RNE → 0x7F800000 (upper word per FP_RND_NANBOX_EN), flags 00101.
- RTZ → 0x7F7FFFFF, flags 00101.
REQ-032 SHALL cover special cases: snan → 0x7FF8000000000000, flags 10000; diff zero under RDN → 0x8000000000000000, flags 0.
REQ-033 SHALL cover backpressure: 3 back-to-back operands with out_ready=0 → in_ready drops once out_valid=1, result held stable, all 3 delivered in order after out_ready=1.
REQ-034 SHALL cover mid-operation reset: reset for 1 cycle with 2 operands in flight → out_valid stays 0 until a new operand is accepted.
